// File: rtl/fw_pkg.sv
// Shared definitions for the port-scan detector: FSM encoding, per-entry
// status record, index-width helper and the alert-overflow counter width.
package fw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_UPDATE = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Per-entry status bits; IP, MAC, slots and count live in parallel arrays
  // because their widths follow the top-level parameters.
  typedef struct packed {
    logic valid;
    logic flagged;
  } ent_flags_t;

  localparam int unsigned OVF_W = 8;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/pscan_entry_match.sv
// Compares one tracked-source entry against the latched source IP and port.
module pscan_entry_match
  import fw_pkg::*;
#(
  parameter int unsigned IP_W   = 32,
  parameter int unsigned PORT_W = 16,
  parameter int unsigned SLOTS  = 8,
  parameter int unsigned SLOT_W = 3
) (
  input  logic                          ent_valid,
  input  logic [IP_W-1:0]               ent_ip,
  input  logic [SLOTS-1:0]              ent_sval,
  input  logic [SLOTS-1:0][PORT_W-1:0]  ent_port,
  input  logic [IP_W-1:0]               key_ip,
  input  logic [PORT_W-1:0]             key_port,
  output logic                          hit,
  output logic                          port_seen,
  output logic                          free_found,
  output logic [SLOT_W-1:0]             first_free_slot
);

  // Hit on valid IP match; scan slots for the port and the lowest free slot.
  always_comb begin
    hit             = ent_valid && (ent_ip == key_ip);
    port_seen       = 1'b0;
    free_found      = 1'b0;
    first_free_slot = '0;
    for (int unsigned s = 0; s < SLOTS; s++) begin
      if (ent_sval[s] && (ent_port[s] == key_port)) port_seen = 1'b1;
      if (!ent_sval[s] && !free_found) begin
        free_found      = 1'b1;
        first_free_slot = SLOT_W'(s);
      end
    end
  end

endmodule

// File: rtl/port_scan_detector_param.sv
// Port-scan detector: per-source distinct-port tracking within a time
// window, per-packet pass/drop verdict and a single pending alert record.
module port_scan_detector_param
  import fw_pkg::*;
#(
  parameter int unsigned IP_W          = 32,
  parameter int unsigned MAC_W         = 48,
  parameter int unsigned PORT_W        = 16,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned SLOTS         = 8,
  parameter int unsigned THRESHOLD     = 5,
  parameter int unsigned WINDOW_CYCLES = 100_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IP_W-1:0]   in_ip,
  input  logic [MAC_W-1:0]  in_mac,
  input  logic [PORT_W-1:0] in_port,
  output logic              verdict_valid,
  output logic              verdict_drop,
  output logic              alert_valid,
  input  logic              alert_ready,
  output logic [IP_W-1:0]   alert_ip,
  output logic [MAC_W-1:0]  alert_mac,
  output logic [PORT_W-1:0] alert_port,
  output logic [7:0]        alert_overflow
);

  localparam int unsigned IDX_W  = idx_w(DEPTH);
  localparam int unsigned SLOT_W = idx_w(SLOTS);
  localparam int unsigned CNT_W  = idx_w(SLOTS + 1);
  localparam int unsigned WIN_W  = idx_w(WINDOW_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_THR  = CNT_W'(THRESHOLD);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic FLAG_FIRST = (THRESHOLD == 1);

  state_e state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d, hit_idx_q, hit_idx_d, free_idx_q, free_idx_d, rr_q, rr_d;
  logic              hit_q, hit_d, free_found_q, free_found_d, drop_q, drop_d, clr_q, clr_d;
  logic [IP_W-1:0]   ip_q, ip_d;
  logic [MAC_W-1:0]  mac_q, mac_d;
  logic [PORT_W-1:0] port_q, port_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic              alert_valid_q, alert_valid_d;
  logic [IP_W-1:0]   alert_ip_q, alert_ip_d;
  logic [MAC_W-1:0]  alert_mac_q, alert_mac_d;
  logic [PORT_W-1:0] alert_port_q, alert_port_d;
  logic [OVF_W-1:0]  ovf_q, ovf_d;

  ent_flags_t                 ent_q      [DEPTH], ent_d      [DEPTH];
  logic [IP_W-1:0]            ent_ip_q   [DEPTH], ent_ip_d   [DEPTH];
  logic [MAC_W-1:0]           ent_mac_q  [DEPTH], ent_mac_d  [DEPTH];
  logic [SLOTS-1:0]           ent_sval_q [DEPTH], ent_sval_d [DEPTH];
  logic [SLOTS-1:0][PORT_W-1:0] ent_port_q [DEPTH], ent_port_d [DEPTH];
  logic [CNT_W-1:0]           ent_cnt_q  [DEPTH], ent_cnt_d  [DEPTH];

  logic              raise;
  logic [IDX_W-1:0]  tgt, m_idx;
  logic [CNT_W-1:0]  new_cnt;
  logic              m_hit, m_port_seen, m_free_found;
  logic [SLOT_W-1:0] m_free_slot;

  // The single comparator scans entries in SEARCH and re-examines the hit entry in UPDATE.
  assign m_idx = (state_q == ST_SEARCH) ? idx_q : hit_idx_q;

  pscan_entry_match #(
    .IP_W  (IP_W),
    .PORT_W(PORT_W),
    .SLOTS (SLOTS),
    .SLOT_W(SLOT_W)
  ) u_match (
    .ent_valid      (ent_q[m_idx].valid),
    .ent_ip         (ent_ip_q[m_idx]),
    .ent_sval       (ent_sval_q[m_idx]),
    .ent_port       (ent_port_q[m_idx]),
    .key_ip         (ip_q),
    .key_port       (port_q),
    .hit            (m_hit),
    .port_seen      (m_port_seen),
    .free_found     (m_free_found),
    .first_free_slot(m_free_slot)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state: one cycle per entry in SEARCH, then UPDATE and RESP.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (in_valid && in_ready) state_d = ST_SEARCH;
      ST_SEARCH: if (idx_q == IDX_LAST) state_d = ST_UPDATE;
      ST_UPDATE: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: accept only in IDLE without a pending window clear.
  always_comb begin
    in_ready      = (state_q == ST_IDLE) && !clr_q;
    verdict_valid = (state_q == ST_RESP);
    verdict_drop  = (state_q == ST_RESP) && drop_q;
  end

  // Datapath: latch, search bookkeeping, table update, window clear, alert slot.
  always_comb begin
    idx_d = idx_q;  hit_d = hit_q;  hit_idx_d = hit_idx_q;
    free_found_d = free_found_q;  free_idx_d = free_idx_q;
    ip_d = ip_q;  mac_d = mac_q;  port_d = port_q;  drop_d = drop_q;
    rr_d = rr_q;  clr_d = clr_q;
    alert_valid_d = alert_valid_q;  alert_ip_d = alert_ip_q;
    alert_mac_d = alert_mac_q;  alert_port_d = alert_port_q;  ovf_d = ovf_q;
    ent_d = ent_q;  ent_ip_d = ent_ip_q;  ent_mac_d = ent_mac_q;
    ent_sval_d = ent_sval_q;  ent_port_d = ent_port_q;  ent_cnt_d = ent_cnt_q;
    raise = 1'b0;  tgt = rr_q;  new_cnt = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (clr_q) begin
          for (int unsigned i = 0; i < DEPTH; i++) begin
            ent_d[i]      = '0;
            ent_sval_d[i] = '0;
          end
          rr_d  = '0;
          clr_d = 1'b0;
        end else if (in_valid) begin
          ip_d = in_ip;  mac_d = in_mac;  port_d = in_port;
          idx_d = '0;  hit_d = 1'b0;  free_found_d = 1'b0;
        end
      end
      ST_SEARCH: begin
        if (m_hit && !hit_q) begin
          hit_d = 1'b1;  hit_idx_d = idx_q;
        end
        if (!ent_q[idx_q].valid && !free_found_q) begin
          free_found_d = 1'b1;  free_idx_d = idx_q;
        end
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end
      ST_UPDATE: begin
        if (hit_q) begin
          if (ent_q[hit_idx_q].flagged) begin
            drop_d = 1'b1;
          end else if (m_port_seen || !m_free_found) begin
            drop_d = 1'b0;
          end else begin
            new_cnt = ent_cnt_q[hit_idx_q] + CNT_W'(1);
            ent_sval_d[hit_idx_q][m_free_slot] = 1'b1;
            ent_port_d[hit_idx_q][m_free_slot] = port_q;
            ent_cnt_d[hit_idx_q] = new_cnt;
            drop_d = (new_cnt == CNT_THR);
            raise  = (new_cnt == CNT_THR);
            if (new_cnt == CNT_THR) ent_d[hit_idx_q].flagged = 1'b1;
          end
        end else begin
          if (free_found_q) begin
            tgt = free_idx_q;
          end else begin
            tgt  = rr_q;
            rr_d = (rr_q == IDX_LAST) ? '0 : rr_q + IDX_W'(1);
          end
          ent_d[tgt].valid   = 1'b1;
          ent_d[tgt].flagged = FLAG_FIRST;
          ent_ip_d[tgt]      = ip_q;
          ent_mac_d[tgt]     = mac_q;
          ent_sval_d[tgt]    = SLOTS'(1);
          ent_port_d[tgt][0] = port_q;
          ent_cnt_d[tgt]     = CNT_W'(1);
          drop_d = FLAG_FIRST;
          raise  = FLAG_FIRST;
        end
      end
      default: ;
    endcase

    // Window wrap arms a clear; a wrap coinciding with a clear re-arms it.
    win_d = (win_q == WIN_LAST) ? '0 : win_q + WIN_W'(1);
    if (win_q == WIN_LAST) clr_d = 1'b1;

    // A take in the same cycle frees the slot for the new alert, so no overflow.
    if (alert_valid_q && alert_ready) alert_valid_d = 1'b0;
    if (raise) begin
      if (!alert_valid_q || alert_ready) begin
        alert_valid_d = 1'b1;
        alert_ip_d    = ip_q;
        alert_mac_d   = hit_q ? ent_mac_q[hit_idx_q] : mac_q;
        alert_port_d  = port_q;
      end else if (ovf_q != '1) begin
        ovf_d = ovf_q + OVF_W'(1);
      end
    end
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;  hit_q <= 1'b0;  hit_idx_q <= '0;
      free_found_q <= 1'b0;  free_idx_q <= '0;
      ip_q <= '0;  mac_q <= '0;  port_q <= '0;  drop_q <= 1'b0;
      rr_q <= '0;  win_q <= '0;  clr_q <= 1'b0;
      alert_valid_q <= 1'b0;  alert_ip_q <= '0;  alert_mac_q <= '0;
      alert_port_q <= '0;  ovf_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_q[i]      <= '0;
        ent_sval_q[i] <= '0;
        ent_cnt_q[i]  <= '0;
      end
    end else begin
      idx_q <= idx_d;  hit_q <= hit_d;  hit_idx_q <= hit_idx_d;
      free_found_q <= free_found_d;  free_idx_q <= free_idx_d;
      ip_q <= ip_d;  mac_q <= mac_d;  port_q <= port_d;  drop_q <= drop_d;
      rr_q <= rr_d;  win_q <= win_d;  clr_q <= clr_d;
      alert_valid_q <= alert_valid_d;  alert_ip_q <= alert_ip_d;
      alert_mac_q <= alert_mac_d;  alert_port_q <= alert_port_d;  ovf_q <= ovf_d;
      ent_q <= ent_d;  ent_sval_q <= ent_sval_d;  ent_cnt_q <= ent_cnt_d;
    end
  end

  // Entry payload storage; meaningful only under the valid/slot-valid bits.
  always_ff @(posedge clk) begin
    ent_ip_q   <= ent_ip_d;
    ent_mac_q  <= ent_mac_d;
    ent_port_q <= ent_port_d;
  end

  assign alert_valid    = alert_valid_q;
  assign alert_ip       = alert_ip_q;
  assign alert_mac      = alert_mac_q;
  assign alert_port     = alert_port_q;
  assign alert_overflow = ovf_q;

endmodule

// File: tb/tb_port_scan_detector_param.sv
// Self-checking bench for port_scan_detector_param: vector tables through a
// verdict scoreboard plus directed alert, window and reset sequences.
module tb_port_scan_detector_param;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned SLOTS = 8;
  localparam int unsigned THR   = 5;
  localparam int unsigned WIN   = 256;

  logic        clk, rst, in_valid, in_ready;
  logic [31:0] in_ip;
  logic [47:0] in_mac;
  logic [15:0] in_port;
  logic        verdict_valid, verdict_drop, alert_valid, alert_ready;
  logic [31:0] alert_ip;
  logic [47:0] alert_mac;
  logic [15:0] alert_port;
  logic [7:0]  alert_overflow;

  port_scan_detector_param #(
    .IP_W(32), .MAC_W(48), .PORT_W(16), .DEPTH(DEPTH), .SLOTS(SLOTS),
    .THRESHOLD(THR), .WINDOW_CYCLES(WIN)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ip(in_ip), .in_mac(in_mac), .in_port(in_port),
    .verdict_valid(verdict_valid), .verdict_drop(verdict_drop),
    .alert_valid(alert_valid), .alert_ready(alert_ready),
    .alert_ip(alert_ip), .alert_mac(alert_mac), .alert_port(alert_port),
    .alert_overflow(alert_overflow)
  );

  typedef struct {
    logic [31:0] ip;
    logic [15:0] port;
    logic        exp_drop;
    logic        exp_alert;
  } vec_t;

  typedef struct {
    logic        exp_drop;
    logic        exp_alert;
    int unsigned acc;
  } sb_t;

  vec_t        tv[$];
  sb_t         sb_q[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic logic [47:0] mac_of(input logic [31:0] ip);
    return {16'hAA00, ip};
  endfunction

  function automatic vec_t mk(input logic [31:0] ip, input logic [15:0] p,
                              input logic d, input logic a);
    vec_t v;
    v.ip = ip; v.port = p; v.exp_drop = d; v.exp_alert = a;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    sb_t e;
    forever begin
      @(negedge clk);
      if (verdict_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_verdict: verdict_valid=1 at cycle %0d, required 0", cyc);
        end else begin
          e = sb_q.pop_front();
          chk("verdict_drop", 64'(verdict_drop), 64'(e.exp_drop));
          chk("alert_valid_at_verdict", 64'(alert_valid), 64'(e.exp_alert));
          chk("verdict_latency", 64'(cyc - e.acc), 64'(DEPTH + 2));
        end
      end
    end
  endtask

  task automatic send(input vec_t v, input bit expect_verdict, output int unsigned acc);
    int unsigned n = 0;
    acc = 0;
    @(negedge clk);
    in_ip = v.ip; in_mac = mac_of(v.ip); in_port = v.port; in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
    end else begin
      acc = cyc;
      if (expect_verdict) begin
        sb_t e;
        e.exp_drop = v.exp_drop; e.exp_alert = v.exp_alert; e.acc = cyc;
        sb_q.push_back(e);
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: %0d verdicts outstanding, required 0", sb_q.size());
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic run_tv();
    int unsigned acc;
    for (int i = 0; i < tv.size(); i++) send(tv[i], 1'b1, acc);
    drain();
    tv.delete();
  endtask

  task automatic wait_cyc(input int unsigned target);
    int unsigned n = 0;
    while (cyc < target && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (cyc != target) begin
      n_vec++; n_err++;
      $display("FAIL wait_cycle: reached cycle %0d, required %0d", cyc, target);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_verdict_valid", 64'(verdict_valid), 64'd0);
    chk("rst_verdict_drop", 64'(verdict_drop), 64'd0);
    chk("rst_alert_valid", 64'(alert_valid), 64'd0);
    chk("rst_alert_ip", 64'(alert_ip), 64'd0);
    chk("rst_alert_mac", 64'(alert_mac), 64'd0);
    chk("rst_alert_port", 64'(alert_port), 64'd0);
    chk("rst_alert_overflow", 64'(alert_overflow), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; alert_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    sb_q.delete();
    rst = 1'b0;
  endtask

  task automatic pulse_take();
    @(negedge clk);
    alert_ready = 1'b1;
    @(negedge clk);
    alert_ready = 1'b0;
    chk("alert_cleared_after_take", 64'(alert_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned acc;
    rst = 1'b1; in_valid = 1'b0; alert_ready = 1'b0;
    in_ip = '0; in_mac = '0; in_port = '0;
    fork
      monitor();
    join_none

    // Basic trip at the threshold, repeated port, IP 0 / port 0 source.
    do_reset();
    for (int p = 80; p <= 83; p++) tv.push_back(mk(32'h0A000001, 16'(p), 1'b0, 1'b0));
    tv.push_back(mk(32'h0A000001, 16'd84, 1'b1, 1'b1));
    tv.push_back(mk(32'h0A000001, 16'd80, 1'b1, 1'b1));
    for (int k = 0; k < 5; k++) tv.push_back(mk(32'h0A000002, 16'd80, 1'b0, 1'b1));
    tv.push_back(mk(32'h0, 16'd0, 1'b0, 1'b1));
    tv.push_back(mk(32'h0, 16'd0, 1'b0, 1'b1));
    for (int p = 1; p <= 3; p++) tv.push_back(mk(32'h0, 16'(p), 1'b0, 1'b1));
    tv.push_back(mk(32'h0, 16'd4, 1'b1, 1'b1));
    run_tv();
    chk("s1_alert_ip", 64'(alert_ip), 64'h0A000001);
    chk("s1_alert_port", 64'(alert_port), 64'd84);
    chk("s1_alert_mac", 64'(alert_mac), 64'(mac_of(32'h0A000001)));
    chk("s1_overflow", 64'(alert_overflow), 64'd1);
    pulse_take();

    // Eviction: a fifth source displaces entry 0 so its owner restarts at count 1.
    do_reset();
    for (int p = 1; p <= 4; p++) tv.push_back(mk(32'h00000100, 16'(p), 1'b0, 1'b0));
    for (int s = 2; s <= 5; s++) tv.push_back(mk(32'(s * 256), 16'd1, 1'b0, 1'b0));
    for (int p = 5; p <= 8; p++) tv.push_back(mk(32'h00000100, 16'(p), 1'b0, 1'b0));
    tv.push_back(mk(32'h00000100, 16'd9, 1'b1, 1'b1));
    run_tv();
    chk("s2_alert_ip", 64'(alert_ip), 64'h00000100);
    chk("s2_alert_port", 64'(alert_port), 64'd9);

    // Overflow while pending, then raise coinciding with a take.
    do_reset();
    for (int p = 1; p <= 4; p++) tv.push_back(mk(32'h0B000001, 16'(p), 1'b0, 1'b0));
    tv.push_back(mk(32'h0B000001, 16'd5, 1'b1, 1'b1));
    for (int p = 1; p <= 4; p++) tv.push_back(mk(32'h0B000002, 16'(p), 1'b0, 1'b1));
    tv.push_back(mk(32'h0B000002, 16'd5, 1'b1, 1'b1));
    run_tv();
    chk("s3_alert_ip_first", 64'(alert_ip), 64'h0B000001);
    chk("s3_overflow", 64'(alert_overflow), 64'd1);
    pulse_take();
    for (int p = 1; p <= 4; p++) tv.push_back(mk(32'h0B000003, 16'(p), 1'b0, 1'b0));
    tv.push_back(mk(32'h0B000003, 16'd5, 1'b1, 1'b1));
    for (int p = 1; p <= 4; p++) tv.push_back(mk(32'h0B000004, 16'(p), 1'b0, 1'b1));
    run_tv();
    chk("s3_alert_ip_third", 64'(alert_ip), 64'h0B000003);
    send(mk(32'h0B000004, 16'd5, 1'b1, 1'b1), 1'b1, acc);
    wait_cyc(acc + DEPTH + 1);
    alert_ready = 1'b1;
    wait_cyc(acc + DEPTH + 2);
    alert_ready = 1'b0;
    drain();
    chk("s3_same_cycle_alert_ip", 64'(alert_ip), 64'h0B000004);
    chk("s3_same_cycle_overflow", 64'(alert_overflow), 64'd1);

    // Window expiry while the tuple is in SEARCH.
    do_reset();
    for (int p = 1; p <= 4; p++) tv.push_back(mk(32'h0C000001, 16'(p), 1'b0, 1'b0));
    tv.push_back(mk(32'h0C000001, 16'd5, 1'b1, 1'b1));
    run_tv();
    wait_cyc(WIN - 4);
    send(mk(32'h0C000001, 16'd6, 1'b1, 1'b1), 1'b1, acc);
    chk("s4_accept_cycle", 64'(acc), 64'(WIN - 3));
    wait_cyc(WIN + 4);
    chk("s4_clear_in_ready", 64'(in_ready), 64'd0);
    for (int p = 7; p <= 10; p++) tv.push_back(mk(32'h0C000001, 16'(p), 1'b0, 1'b1));
    tv.push_back(mk(32'h0C000001, 16'd11, 1'b1, 1'b1));
    run_tv();
    chk("s4_overflow", 64'(alert_overflow), 64'd1);

    // Reset in the middle of SEARCH abandons the tuple and empties the table.
    do_reset();
    for (int p = 1; p <= 4; p++) tv.push_back(mk(32'h0D000001, 16'(p), 1'b0, 1'b0));
    run_tv();
    send(mk(32'h0D000001, 16'd5, 1'b1, 1'b1), 1'b0, acc);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    repeat (12) @(negedge clk);
    for (int p = 5; p <= 8; p++) tv.push_back(mk(32'h0D000001, 16'(p), 1'b0, 1'b0));
    tv.push_back(mk(32'h0D000001, 16'd9, 1'b1, 1'b1));
    run_tv();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
